// File: rtl/gnn_pkg.sv
// Shared types and default dimensions for the graph pipeline FSMs
// (feature-weight transform and edge aggregation).
package gnn_pkg;

    localparam int NUM_NODES_DEF    = 32'sd6;
    localparam int IN_FEATURES_DEF  = 32'sd3;
    localparam int OUT_FEATURES_DEF = 32'sd2;
    localparam int DATA_W_DEF       = 32'sd8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_MAC   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } fm_wm_state_t;

    // Address width that stays at least one bit for a single-entry dimension.
    function automatic int CLOG2_MIN1(input int n);
        return (n <= 32'sd1) ? 32'sd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fm_wm_mac.sv
// Signed multiply-accumulate with clear/enable and DATA_W reduction.
// FM_WM_SATURATE_EN selects clamping instead of truncation on the output.
module fm_wm_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 19
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] res_o
);

    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;

    function automatic logic [DATA_W-1:0] reduce_acc(input logic signed [ACC_W-1:0] acc);
`ifdef FM_WM_SATURATE_EN
        logic signed [ACC_W-1:0] max_v;
        logic signed [ACC_W-1:0] min_v;
        max_v = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
        min_v = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
        if (acc > max_v) begin
            return max_v[DATA_W-1:0];
        end else if (acc < min_v) begin
            return min_v[DATA_W-1:0];
        end else begin
            return acc[DATA_W-1:0];
        end
`else
        return acc[DATA_W-1:0];
`endif
    endfunction

    assign prod_s = $signed(a_i) * $signed(b_i);
    assign res_o  = reduce_acc(acc_q);

    // Accumulator next value: clear wins over accumulate.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = {ACC_W{1'b0}};
        end else if (en_i) begin
            acc_d = acc_q + ACC_W'(prod_s);
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= {ACC_W{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fm_wm_transform_fsm.sv
// Computes FM_WM = FM x WM one element at a time: FETCH, IN_FEATURES MAC cycles, WRITE.
// FM_WM_SATURATE_EN (in fm_wm_mac) clamps written elements instead of truncating.
module fm_wm_transform_fsm
    import gnn_pkg::*;
#(
    parameter int NUM_NODES    = NUM_NODES_DEF,
    parameter int IN_FEATURES  = IN_FEATURES_DEF,
    parameter int OUT_FEATURES = OUT_FEATURES_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ACC_W        = 2*DATA_W + $clog2(IN_FEATURES) + 1,
    parameter int NODE_W       = CLOG2_MIN1(NUM_NODES),
    parameter int K_W          = CLOG2_MIN1(IN_FEATURES),
    parameter int F_W          = CLOG2_MIN1(OUT_FEATURES)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic [NODE_W-1:0] fm_row_addr_o,
    output logic [K_W-1:0]    fm_col_addr_o,
    output logic [K_W-1:0]    wm_row_addr_o,
    output logic [F_W-1:0]    wm_col_addr_o,
    output logic              fm_wm_read_o,
    input  logic [DATA_W-1:0] fm_data_i,
    input  logic [DATA_W-1:0] wm_data_i,
    output logic              fm_wm_write_en_o,
    output logic [NODE_W-1:0] fm_wm_row_addr_o,
    output logic [F_W-1:0]    fm_wm_col_addr_o,
    output logic [DATA_W-1:0] fm_wm_data_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [NODE_W-1:0] NODE_LAST = NODE_W'(NUM_NODES - 1);
    localparam logic [K_W-1:0]    K_LAST    = K_W'(IN_FEATURES - 1);
    localparam logic [F_W-1:0]    F_LAST    = F_W'(OUT_FEATURES - 1);

    fm_wm_state_t      state_q, state_d;
    logic [NODE_W-1:0] node_q, node_d;
    logic [F_W-1:0]    f_q, f_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [NODE_W-1:0] rd_row_q;
    logic [K_W-1:0]    rd_k_q;
    logic [F_W-1:0]    rd_f_q;
    logic [NODE_W-1:0] wr_row_q;
    logic [F_W-1:0]    wr_col_q;
    logic              rd_s;
    logic [K_W-1:0]    rd_k_s;
    logic              we_s;
    logic              acc_clr_s;
    logic              acc_en_s;
    logic [DATA_W-1:0] mac_res_s;

    // Next-state and strobe decode; k_q is the index of the data arriving this cycle.
    always_comb begin
        state_d   = state_q;
        node_d    = node_q;
        f_d       = f_q;
        k_d       = k_q;
        rd_s      = 1'b0;
        rd_k_s    = k_q;
        we_s      = 1'b0;
        acc_clr_s = 1'b0;
        acc_en_s  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                    node_d  = {NODE_W{1'b0}};
                    f_d     = {F_W{1'b0}};
                    k_d     = {K_W{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_FETCH: begin
                rd_s      = 1'b1;
                rd_k_s    = {K_W{1'b0}};
                acc_clr_s = 1'b1;
                state_d   = ST_MAC;
            end
            ST_MAC: begin
                acc_en_s = 1'b1;
                if (k_q < K_LAST) begin
                    rd_s   = 1'b1;
                    rd_k_s = k_q + K_W'(1);
                    k_d    = k_q + K_W'(1);
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                we_s = 1'b1;
                k_d  = {K_W{1'b0}};
                if (f_q == F_LAST) begin
                    f_d = {F_W{1'b0}};
                    if (node_q == NODE_LAST) begin
                        node_d  = {NODE_W{1'b0}};
                        state_d = ST_DONE;
                    end else begin
                        node_d  = node_q + NODE_W'(1);
                        state_d = ST_FETCH;
                    end
                end else begin
                    f_d     = f_q + F_W'(1);
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and the held copies of the last issued addresses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            node_q   <= {NODE_W{1'b0}};
            f_q      <= {F_W{1'b0}};
            k_q      <= {K_W{1'b0}};
            rd_row_q <= {NODE_W{1'b0}};
            rd_k_q   <= {K_W{1'b0}};
            rd_f_q   <= {F_W{1'b0}};
            wr_row_q <= {NODE_W{1'b0}};
            wr_col_q <= {F_W{1'b0}};
        end else begin
            state_q <= state_d;
            node_q  <= node_d;
            f_q     <= f_d;
            k_q     <= k_d;
            if (rd_s) begin
                rd_row_q <= node_q;
                rd_k_q   <= rd_k_s;
                rd_f_q   <= f_q;
            end
            if (we_s) begin
                wr_row_q <= node_q;
                wr_col_q <= f_q;
            end
        end
    end

    fm_wm_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (acc_clr_s),
        .en_i   (acc_en_s),
        .a_i    (fm_data_i),
        .b_i    (wm_data_i),
        .res_o  (mac_res_s)
    );

    assign fm_wm_read_o     = rd_s;
    assign fm_row_addr_o    = rd_s ? node_q : rd_row_q;
    assign fm_col_addr_o    = rd_s ? rd_k_s : rd_k_q;
    assign wm_row_addr_o    = rd_s ? rd_k_s : rd_k_q;
    assign wm_col_addr_o    = rd_s ? f_q : rd_f_q;
    assign fm_wm_write_en_o = we_s;
    assign fm_wm_row_addr_o = we_s ? node_q : wr_row_q;
    assign fm_wm_col_addr_o = we_s ? f_q : wr_col_q;
    assign fm_wm_data_o     = we_s ? mac_res_s : {DATA_W{1'b0}};
    assign busy_o           = (state_q == ST_FETCH) || (state_q == ST_MAC) || (state_q == ST_WRITE);
    assign done_o           = (state_q == ST_DONE);

endmodule

// File: tb/tb_fm_wm_transform_fsm.sv
// Scoreboard bench for fm_wm_transform_fsm: memory models, arithmetic reference, write monitor.
module tb_fm_wm_transform_fsm;

    localparam int NN = 6;
    localparam int NI = 3;
    localparam int NO = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] fm_row_addr;
    logic [1:0] fm_col_addr;
    logic [1:0] wm_row_addr;
    logic [0:0] wm_col_addr;
    logic       fm_wm_read;
    logic [7:0] fm_data = 8'h00;
    logic [7:0] wm_data = 8'h00;
    logic       fm_wm_write_en;
    logic [2:0] fm_wm_row_addr;
    logic [0:0] fm_wm_col_addr;
    logic [7:0] fm_wm_data;
    logic       busy;
    logic       done;

    logic signed [7:0] fm_mem [NN][NI];
    logic signed [7:0] wm_mem [NI][NO];
    logic [7:0]        obs    [NN][NO];

    typedef struct {
        int         row;
        int         col;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    fm_wm_transform_fsm dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .start_i          (start),
        .fm_row_addr_o    (fm_row_addr),
        .fm_col_addr_o    (fm_col_addr),
        .wm_row_addr_o    (wm_row_addr),
        .wm_col_addr_o    (wm_col_addr),
        .fm_wm_read_o     (fm_wm_read),
        .fm_data_i        (fm_data),
        .wm_data_i        (wm_data),
        .fm_wm_write_en_o (fm_wm_write_en),
        .fm_wm_row_addr_o (fm_wm_row_addr),
        .fm_wm_col_addr_o (fm_wm_col_addr),
        .fm_wm_data_o     (fm_wm_data),
        .busy_o           (busy),
        .done_o           (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read FM and WM memories, one cycle of latency.
    always @(posedge clk) begin
        if (fm_wm_read) begin
            fm_data <= fm_mem[fm_row_addr][fm_col_addr];
            wm_data <= wm_mem[wm_row_addr][wm_col_addr];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is matched against the head of the expected queue.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && fm_wm_write_en) begin
            obs[fm_wm_row_addr][fm_wm_col_addr] = fm_wm_data;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: actual row %0d col %0d data 0x%0h, required no write",
                         fm_wm_row_addr, fm_wm_col_addr, fm_wm_data);
            end else begin
                e = exp_q.pop_front();
                check("write_elem", {8'h00, 5'd0, fm_wm_row_addr, 7'd0, fm_wm_col_addr, fm_wm_data},
                      (e.row << 16) | (e.col << 8) | int'(e.data));
            end
        end
    end

    // Reference: dot product over k with plain integers, then the output reduction.
    task automatic push_pass();
        exp_t e;
        int   acc;
        for (int n = 0; n < NN; n++) begin
            for (int f = 0; f < NO; f++) begin
                acc = 0;
                for (int k = 0; k < NI; k++) acc += int'(fm_mem[n][k]) * int'(wm_mem[k][f]);
`ifdef FM_WM_SATURATE_EN
                if (acc > 127) acc = 127;
                if (acc < -128) acc = -128;
`endif
                e.row  = n;
                e.col  = f;
                e.data = acc[7:0];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic fill_random();
        for (int n = 0; n < NN; n++)
            for (int k = 0; k < NI; k++) fm_mem[n][k] = 8'($urandom_range(0, 255));
        for (int k = 0; k < NI; k++)
            for (int f = 0; f < NO; f++) wm_mem[k][f] = 8'($urandom_range(0, 255));
    endtask

    task automatic do_pass(input string tag, input bit poke_mac);
        int cyc;
        push_pass();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, "_busy_fetch"}, int'(busy), 1);
        check({tag, "_done_low"}, int'(done), 0);
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = poke_mac && (cyc == 2);
        end
        start = 1'b0;
        check({tag, "_done_latency"}, cyc, 60);
        check({tag, "_writes_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin : stim
        int   cyc;
        int   dcnt;
        int   first;
        logic [7:0] ovf_exp;

        for (int n = 0; n < NN; n++)
            for (int k = 0; k < NI; k++) fm_mem[n][k] = 8'(n * NI + k + 1);
        for (int k = 0; k < NI; k++)
            for (int f = 0; f < NO; f++) wm_mem[k][f] = (k == f) ? 8'sd1 : 8'sd0;

        #1;
        check("reset_outputs", int'(|{fm_row_addr, fm_col_addr, wm_row_addr, wm_col_addr, fm_wm_read,
              fm_wm_write_en, fm_wm_row_addr, fm_wm_col_addr, fm_wm_data, busy, done}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        do_pass("identity", 1'b0);
        check("identity_row5", int'({obs[5][0], obs[5][1]}), 32'h1011);

        fill_random();
        fm_mem[0][0] = -8'sd2; fm_mem[0][1] = 8'sd3;  fm_mem[0][2] = -8'sd4;
        wm_mem[0][0] = 8'sd5;  wm_mem[1][0] = -8'sd6; wm_mem[2][0] = 8'sd7;
        do_pass("signed_poke_mac", 1'b1);
        check("signed_e00", int'(obs[0][0]), 32'hC8);

        for (int n = 0; n < NN; n++)
            for (int k = 0; k < NI; k++) fm_mem[n][k] = 8'sd127;
        for (int k = 0; k < NI; k++)
            for (int f = 0; f < NO; f++) wm_mem[k][f] = 8'sd127;
`ifdef FM_WM_SATURATE_EN
        ovf_exp = 8'h7F;
`else
        ovf_exp = 8'h03;
`endif
        do_pass("overflow", 1'b0);
        check("overflow_e21", int'(obs[2][1]), int'(ovf_exp));

        for (int r = 0; r < 3; r++) begin
            fill_random();
            do_pass("random", 1'b0);
        end

        fill_random();
        push_pass();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_read_active", int'(fm_wm_read), 1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", int'(|{fm_row_addr, fm_col_addr, wm_row_addr, wm_col_addr, fm_wm_read,
              fm_wm_write_en, fm_wm_row_addr, fm_wm_col_addr, fm_wm_data, busy, done}), 0);
        check("mid_reset_writes_left", exp_q.size(), NN * NO - 1);
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        do_pass("after_reset", 1'b0);

        fill_random();
        push_pass();
        push_pass();
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        cyc   = 0;
        dcnt  = 0;
        first = -1;
        while (cyc < 121) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                dcnt++;
                if (first < 0) first = cyc;
            end
        end
        start = 1'b0;
        check("b2b_first_done", first, 60);
        check("b2b_done_cycles", dcnt, 2);
        check("b2b_second_done", int'(done), 1);
        check("b2b_writes_left", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("b2b_held_done", int'(done), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
